dmem_responder: RTL
===================

# dmem_responder

Responder side of the core's data-memory port: it accepts word-addressed loads and byte-enabled stores from the pipeline's MEM stage and returns load data in the same cycle. Stores are posted into a small store buffer that drains into the backing array one word per cycle. The array's single write port is shared with a priority backdoor port used by the bench to initialise memory. The block sits between the core top and the data SRAM model in the simulation top.

## Interface
Parameters:
- DEPTH, 4: number of store-buffer entries (2..16).
- ADDR_W, 12: word-address width; the array holds 2**ADDR_W 32-bit words.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RSTn  input  1  reset, synchronous, active-low.
- D_MEM_CSN  input  1  chip select, active-low; 1 means the port is idle.
- D_MEM_ADDR  input  ADDR_W  word address.
- D_MEM_WEN  input  1  write enable, active-low; 0 means store, 1 means load.
- D_MEM_BE  input  4  byte enables; bit i selects byte lane [8i+7:8i].
- D_MEM_DOUT  input  32  store data from the core.
- D_MEM_DI  output  32  load data to the core, combinational.
- BD_WE  input  1  backdoor word write, active-high.
- BD_ADDR  input  ADDR_W  backdoor address.
- BD_DATA  input  32  backdoor data.
- SB_COUNT  output  $clog2(DEPTH+1)  number of valid buffer entries.
- SB_FULL  output  1  SB_COUNT == DEPTH.
- SB_EMPTY  output  1  SB_COUNT == 0.
- OVERFLOW  output  1  sticky flag; set when a store is dropped.

## Operation
- A store is a cycle with CSN=0, WEN=0 and BE≠0. A store with BE=0 is ignored.
- A load is a cycle with CSN=0 and WEN=1. D_MEM_DI = 0 whenever CSN=1 or WEN=0.
- The store buffer is a FIFO of {addr, data, be} entries, oldest at the head.
- Store acceptance, in priority order:
  - Coalesce: if the buffer is non-empty and the newest entry has the same address, merge the enabled bytes of the new store into that entry and OR its be. No new entry is allocated.
  - Allocate: if a slot is free, including a slot freed by this cycle's drain, append a new entry.
  - Drop: otherwise discard the store and set OVERFLOW.
- Drain: each cycle the buffer is non-empty and BD_WE=0, the head entry's enabled bytes are written into the array and the head is popped. When BD_WE=1, the backdoor write takes the array write port and the drain stalls.
- The backdoor writes the full word and never modifies buffer entries. Pending entries drain later and overwrite their enabled bytes.
- Load data: the array word, overlaid byte-by-byte with every valid buffer entry matching D_MEM_ADDR, applied oldest to newest. The newest write wins per byte. A store issued in the current cycle is not visible to the same-cycle read.
- Array contents are not reset.

## Timing
- Reset (RSTn=0 at a rising edge) clears the buffer and OVERFLOW. Resulting output values: SB_COUNT=0, SB_EMPTY=1, SB_FULL=0, OVERFLOW=0.
- While RSTn=0, stores and drains are ignored. A backdoor write still completes.
- Reset during a drain discards all pending entries; a drain in the reset cycle is not performed.
- Load latency is 0 cycles (combinational from ADDR). A store becomes visible to loads one cycle after its edge.
- Store-to-array latency is 1 + (entries ahead of it) + (BD_WE stall cycles).
- Same-cycle enqueue and drain with the buffer full: the store is allocated and SB_COUNT stays at DEPTH.
- A store that coalesces into the head entry in the same cycle the head drains: treat it as an allocate into a new entry. The drained word carries the old data only.
- OVERFLOW stays set until reset.

## Configuration
- DMEM_STORE_FWD_EN defined: loads overlay matching buffer bytes as described above.
- DMEM_STORE_FWD_EN undefined: D_MEM_DI is the array word only, and pending stores are invisible until drained. The bench must insert DEPTH+1 idle cycles between a store and a dependent load. Coalescing, drain and OVERFLOW are unchanged.

## Test plan
- Backdoor writes 0x11223344 to addr 5. Load addr 5 → D_MEM_DI=0x11223344. Load with CSN=1 → D_MEM_DI=0.
- Store 0xAABBCCDD with BE=4'b0011 to addr 5, then load addr 5 next cycle (forwarding on) → 0x1122CCDD. After the drain, SB_EMPTY=1 and the array holds 0x1122CCDD.
- Hold BD_WE=1 and issue DEPTH stores to distinct addresses → SB_FULL=1. Issue one more store to a new address → dropped, OVERFLOW=1. Issue a store to the newest entry's address → coalesced, SB_COUNT=DEPTH.
- Buffer full with BD_WE=0, store to a new address in the same cycle as a drain → accepted, SB_COUNT stays DEPTH, OVERFLOW stays 0.
- Two stores to addr 9 with BE=1000 (0xEE000000) then BE=0001 (0x000000FF), issued back-to-back while the drain is stalled → one entry with be=1001. Load addr 9 → bytes 3 and 0 equal 0xEE and 0xFF.
- Assert RSTn=0 for one edge with 3 pending entries → SB_COUNT=0 and OVERFLOW=0. Array words at those addresses are unchanged.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the core's MEM stage.
// Loads return data combinationally; stores are posted into a DEPTH-entry
// store buffer (with same-address coalescing) that drains one word per cycle
// into a 2**ADDR_W x 32 array. A backdoor write port has priority over drain.
//
// Ports:
//   CLK, RSTn                 clock, synchronous active-low reset
//   D_MEM_CSN/ADDR/WEN/BE     core request (CSN/WEN active-low)
//   D_MEM_DOUT                store data from the core
//   D_MEM_DI                  load data to the core (combinational)
//   BD_WE/BD_ADDR/BD_DATA     backdoor full-word write
//   SB_COUNT/SB_FULL/SB_EMPTY store-buffer occupancy status
//   OVERFLOW                  sticky dropped-store flag
//
// Optional feature: define DMEM_STORE_FWD_EN to forward pending buffer bytes
// to loads. Without it, loads see the array word only.
module dmem_responder #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 12
) (
  input  logic                         CLK,
  input  logic                         RSTn,
  input  logic                         D_MEM_CSN,
  input  logic [ADDR_W-1:0]            D_MEM_ADDR,
  input  logic                         D_MEM_WEN,
  input  logic [3:0]                   D_MEM_BE,
  input  logic [31:0]                  D_MEM_DOUT,
  output logic [31:0]                  D_MEM_DI,
  input  logic                         BD_WE,
  input  logic [ADDR_W-1:0]            BD_ADDR,
  input  logic [31:0]                  BD_DATA,
  output logic [$clog2(DEPTH+1)-1:0]   SB_COUNT,
  output logic                         SB_FULL,
  output logic                         SB_EMPTY,
  output logic                         OVERFLOW
);

  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned WORDS = 2 ** ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [3:0]        be;
  } sb_entry_t;

  // Buffer is a shift FIFO: index 0 is the head (oldest).
  sb_entry_t         sb_q [DEPTH];
  sb_entry_t         sb_d [DEPTH];
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;

  logic [31:0]       mem_q [WORDS];

  logic              store_c;
  logic              drain_c;
  logic              coalesce_c;
  logic              alloc_c;
  logic [CW-1:0]     cnt_after_c;
  sb_entry_t         newest_c;

  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [31:0]       mem_wdata_c;
  logic [3:0]        mem_be_c;
  logic [31:0]       rd_c;

  assign store_c = !D_MEM_CSN && !D_MEM_WEN && (D_MEM_BE != 4'b0000);
  assign drain_c = RSTn && (cnt_q != '0) && !BD_WE;

  // Next-state for the store buffer: drain shift first, then coalesce/allocate/drop.
  always_comb begin
    sb_d        = sb_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    newest_c    = sb_q[0];
    cnt_after_c = cnt_q;
    coalesce_c  = 1'b0;
    alloc_c     = 1'b0;

    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CW'(i) + CW'(1) == cnt_q) newest_c = sb_q[i];
    end

    if (drain_c) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) sb_d[i] = sb_q[i + 1];
      cnt_after_c = cnt_q - CW'(1);
    end

    // A newest entry that is also the draining head is gone: that case allocates.
    coalesce_c = store_c && (cnt_after_c != '0) && (newest_c.addr == D_MEM_ADDR);
    alloc_c    = store_c && !coalesce_c && (cnt_after_c != CW'(DEPTH));

    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (coalesce_c && (CW'(i) + CW'(1) == cnt_after_c)) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (D_MEM_BE[b]) sb_d[i].data[8*b +: 8] = D_MEM_DOUT[8*b +: 8];
        end
        sb_d[i].be = sb_d[i].be | D_MEM_BE;
      end
      if (alloc_c && (CW'(i) == cnt_after_c)) begin
        sb_d[i].addr = D_MEM_ADDR;
        sb_d[i].data = D_MEM_DOUT;
        sb_d[i].be   = D_MEM_BE;
      end
    end

    cnt_d = cnt_after_c + CW'(alloc_c);
    if (store_c && !coalesce_c && !alloc_c) ovf_d = 1'b1;

    full_d  = (cnt_d == CW'(DEPTH));
    empty_d = (cnt_d == '0);
  end

  // Buffer state registers.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      sb_q    <= sb_d;
    end
  end

  // Array write port: backdoor has priority, otherwise drain the head.
  always_comb begin
    mem_we_c    = 1'b0;
    mem_addr_c  = sb_q[0].addr;
    mem_wdata_c = sb_q[0].data;
    mem_be_c    = sb_q[0].be;
    if (BD_WE) begin
      mem_we_c    = 1'b1;
      mem_addr_c  = BD_ADDR;
      mem_wdata_c = BD_DATA;
      mem_be_c    = 4'b1111;
    end else if (drain_c) begin
      mem_we_c = 1'b1;
    end
  end

  // Backing array, not reset.
  always_ff @(posedge CLK) begin
    if (mem_we_c) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (mem_be_c[b]) mem_q[mem_addr_c][8*b +: 8] <= mem_wdata_c[8*b +: 8];
      end
    end
  end

  // Load path: array word, optionally overlaid oldest-to-newest by pending stores.
  always_comb begin
    rd_c = mem_q[D_MEM_ADDR];
`ifdef DMEM_STORE_FWD_EN
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < cnt_q) && (sb_q[i].addr == D_MEM_ADDR)) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (sb_q[i].be[b]) rd_c[8*b +: 8] = sb_q[i].data[8*b +: 8];
        end
      end
    end
`endif
    D_MEM_DI = (!D_MEM_CSN && D_MEM_WEN) ? rd_c : 32'h0;
  end

  assign SB_COUNT = cnt_q;
  assign SB_FULL  = full_q;
  assign SB_EMPTY = empty_q;
  assign OVERFLOW = ovf_q;

endmodule
